// File: rtl/soc_periph_router.sv
// ---------------------------------------------------------------------------
// soc_periph_router
//
// Single-master to multi-slave peripheral router.  A master request is
// accepted in IDLE, its address is decoded against a fixed SoC memory map,
// and the latched request is presented to exactly one slave.  The router
// then waits for that slave's grant and response.  A slave that grants but
// never answers is timed out, and an address that matches no region gets an
// error response.  Only one transaction is outstanding at a time.
//
// Parameters
//   NumSlv        : number of slave ports (0 DRAM, 1 GPIO, 2 Ethernet, 3 SPI,
//                   4 Timer, 5 UART, 6 PLIC, 7 CLINT, 8 ROM, 9 Debug)
//   TimeoutCycles : response-wait cycles before an error response
//
// Ports
//   clk_i, rst_i             : clock (rising edge), async active-high reset
//   req_i, addr_i, we_i,
//   wdata_i, be_i            : master request
//   gnt_o                    : request accepted (combinational, IDLE only)
//   rvalid_o, rdata_o, err_o : registered one-cycle response
//   slv_req_o                : one-hot slave request (held while in REQ)
//   slv_addr_o, slv_we_o,
//   slv_wdata_o, slv_be_o    : latched request fields
//   slv_gnt_i, slv_rvalid_i,
//   slv_err_i, slv_rdata_i   : per-slave grant / response (slave k data in
//                              slv_rdata_i[64k+63:64k])
//
// Optional feature (macro SOC_ROUTER_ERRLOG_EN)
//   err_addr_o, err_valid_o  : address of the first decode miss or timeout,
//                              sticky until reset
// ---------------------------------------------------------------------------
module soc_periph_router #(
   parameter int NumSlv        = 10,
   parameter int TimeoutCycles = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic [63:0]          addr_i,
   input  logic                 we_i,
   input  logic [63:0]          wdata_i,
   input  logic [7:0]           be_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [63:0]          rdata_o,
   output logic                 err_o,
   output logic [NumSlv-1:0]    slv_req_o,
   output logic [63:0]          slv_addr_o,
   output logic                 slv_we_o,
   output logic [63:0]          slv_wdata_o,
   output logic [7:0]           slv_be_o,
   input  logic [NumSlv-1:0]    slv_gnt_i,
   input  logic [NumSlv-1:0]    slv_rvalid_i,
   input  logic [NumSlv-1:0]    slv_err_i,
   input  logic [NumSlv*64-1:0] slv_rdata_i
`ifdef SOC_ROUTER_ERRLOG_EN
   ,
   output logic [63:0]          err_addr_o,
   output logic                 err_valid_o
`endif
);

   localparam int IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
   localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   // Region bases and lengths are 65 bits wide so that base+length of the
   // DRAM region (0x1_0000_0000) is representable without wrapping.
   function automatic logic [64:0] region_base(input int k);
      case (k)
         0:       region_base = 65'h0_4000_0000; // DRAM
         1:       region_base = 65'h0_2100_0000; // GPIO
         2:       region_base = 65'h0_2200_0000; // Ethernet
         3:       region_base = 65'h0_2000_0000; // SPI
         4:       region_base = 65'h0_1800_0000; // Timer
         5:       region_base = 65'h0_1000_0000; // UART
         6:       region_base = 65'h0_0C00_0000; // PLIC
         7:       region_base = 65'h0_0200_0000; // CLINT
         8:       region_base = 65'h0_3000_0000; // ROM
         9:       region_base = 65'h0_0000_0000; // Debug
         default: region_base = '0;
      endcase
   endfunction

   function automatic logic [64:0] region_len(input int k);
      case (k)
         0:       region_len = 65'h0_C000_0000;
         1:       region_len = 65'h0_0000_1000;
         2:       region_len = 65'h0_0001_0000;
         3:       region_len = 65'h0_0080_0000;
         4:       region_len = 65'h0_0000_1000;
         5:       region_len = 65'h0_0000_1000;
         6:       region_len = 65'h0_03FF_FFFF;
         7:       region_len = 65'h0_000C_0000;
         8:       region_len = 65'h0_1000_0000;
         9:       region_len = 65'h0_0000_1000;
         default: region_len = '0;          // unmapped port never hits
      endcase
   endfunction

   logic [1:0]      state;
   logic [IdxW-1:0] idx;
   logic [CntW-1:0] cnt;
   logic            hit;
   logic [IdxW-1:0] hit_idx;
   logic [63:0]     sel_rdata;

   // Address decode.  Scanning from the highest index down lets the lowest
   // matching index win if regions ever overlap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NumSlv - 1; k >= 0; k--) begin
         if (({1'b0, addr_i} >= region_base(k)) &&
             ({1'b0, addr_i} <  region_base(k) + region_len(k))) begin
            hit     = 1'b1;
            hit_idx = IdxW'(k);
         end
      end
   end

   // Slave request is derived from state so an asynchronous reset drops it
   // in the same instant.
   always_comb begin
      slv_req_o = '0;
      if (state == REQ) slv_req_o[idx] = 1'b1;
   end

   assign gnt_o     = (state == IDLE) && req_i && !rst_i;
   assign sel_rdata = slv_rdata_i[int'(idx)*64 +: 64];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         slv_addr_o  <= '0;
         slv_we_o    <= 1'b0;
         slv_wdata_o <= '0;
         slv_be_o    <= '0;
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
`ifdef SOC_ROUTER_ERRLOG_EN
         err_addr_o  <= '0;
         err_valid_o <= 1'b0;
`endif
      end else begin
         // Response strobes last exactly one cycle; rdata_o holds its value.
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  slv_addr_o  <= addr_i;
                  slv_we_o    <= we_i;
                  slv_wdata_o <= wdata_i;
                  slv_be_o    <= be_i;
                  idx         <= hit_idx;
                  state       <= hit ? REQ : ERR;
`ifdef SOC_ROUTER_ERRLOG_EN
                  if (!hit && !err_valid_o) begin
                     err_addr_o  <= addr_i;
                     err_valid_o <= 1'b1;
                  end
`endif
               end
            end
            REQ: begin
               if (slv_gnt_i[idx]) begin
                  cnt   <= '0;
                  state <= RSP;
               end
            end
            RSP: begin
               cnt <= cnt + 1'b1;
               // Only the selected slave's response is looked at; a response
               // arriving on the final wait cycle still wins over timeout.
               if (slv_rvalid_i[idx]) begin
                  rvalid_o <= 1'b1;
                  rdata_o  <= sel_rdata;
                  err_o    <= slv_err_i[idx];
                  state    <= IDLE;
               end else if (cnt == CntW'(TimeoutCycles - 1)) begin
                  state <= ERR;
`ifdef SOC_ROUTER_ERRLOG_EN
                  if (!err_valid_o) begin
                     err_addr_o  <= slv_addr_o;
                     err_valid_o <= 1'b1;
                  end
`endif
               end
            end
            default: begin // ERR
               rvalid_o <= 1'b1;
               err_o    <= 1'b1;
               rdata_o  <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_periph_router.sv
// ---------------------------------------------------------------------------
// tb_soc_periph_router
//
// Directed plus randomized bench for soc_periph_router.  The bench plays the
// master and all slaves; expected routing comes from a table-driven address
// map model, expected responses from the data the bench itself returns.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_soc_periph_router;

   localparam int N = 10;
   localparam int T = 1024;

   localparam logic [64:0] BASE [N] = '{
      65'h0_4000_0000, 65'h0_2100_0000, 65'h0_2200_0000, 65'h0_2000_0000,
      65'h0_1800_0000, 65'h0_1000_0000, 65'h0_0C00_0000, 65'h0_0200_0000,
      65'h0_3000_0000, 65'h0_0000_0000};
   localparam logic [64:0] LEN [N] = '{
      65'h0_C000_0000, 65'h0_0000_1000, 65'h0_0001_0000, 65'h0_0080_0000,
      65'h0_0000_1000, 65'h0_0000_1000, 65'h0_03FF_FFFF, 65'h0_000C_0000,
      65'h0_1000_0000, 65'h0_0000_1000};

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            req_i;
   logic [63:0]     addr_i;
   logic            we_i;
   logic [63:0]     wdata_i;
   logic [7:0]      be_i;
   logic            gnt_o;
   logic            rvalid_o;
   logic [63:0]     rdata_o;
   logic            err_o;
   logic [N-1:0]    slv_req_o;
   logic [63:0]     slv_addr_o;
   logic            slv_we_o;
   logic [63:0]     slv_wdata_o;
   logic [7:0]      slv_be_o;
   logic [N-1:0]    slv_gnt_i;
   logic [N-1:0]    slv_rvalid_i;
   logic [N-1:0]    slv_err_i;
   logic [N*64-1:0] slv_rdata_i;
`ifdef SOC_ROUTER_ERRLOG_EN
   logic [63:0]     err_addr_o;
   logic            err_valid_o;
`endif

   int total = 0;
   int bad   = 0;

   soc_periph_router #(.NumSlv(N), .TimeoutCycles(T)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .wdata_i      (wdata_i),
      .be_i         (be_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .slv_req_o    (slv_req_o),
      .slv_addr_o   (slv_addr_o),
      .slv_we_o     (slv_we_o),
      .slv_wdata_o  (slv_wdata_o),
      .slv_be_o     (slv_be_o),
      .slv_gnt_i    (slv_gnt_i),
      .slv_rvalid_i (slv_rvalid_i),
      .slv_err_i    (slv_err_i),
      .slv_rdata_i  (slv_rdata_i)
`ifdef SOC_ROUTER_ERRLOG_EN
      ,
      .err_addr_o   (err_addr_o),
      .err_valid_o  (err_valid_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // First (lowest-index) region containing the address, or -1 on a miss.
   function automatic int model_decode(input logic [63:0] a);
      for (int k = 0; k < N; k++)
         if (({1'b0, a} >= BASE[k]) && ({1'b0, a} < BASE[k] + LEN[k])) return k;
      return -1;
   endfunction

   task automatic clear_slaves();
      slv_gnt_i    = '0;
      slv_rvalid_i = '0;
      slv_err_i    = '0;
      slv_rdata_i  = '0;
   endtask

   // One complete master transaction, starting and ending with the router idle.
   task automatic do_txn(input logic [63:0] addr, input logic we, input int gnt_dly,
                         input int rsp_dly, input logic [63:0] data, input logic serr,
                         input logic expect_to);
      int          idx;
      int          other;
      int          k;
      logic [63:0] wd;
      logic [7:0]  be;
      idx = model_decode(addr);
      wd  = {$urandom, $urandom};
      be  = 8'($urandom);
      @(negedge clk_i);
      req_i = 1'b1; addr_i = addr; we_i = we; wdata_i = wd; be_i = be;
      #1 check("gnt_idle", gnt_o, 1);
      @(negedge clk_i);
      // Scramble master inputs: latched fields must not follow them, and a
      // second request must not be granted while busy.
      addr_i = ~addr; wdata_i = ~wd; be_i = ~be; we_i = ~we;
      #1 check("gnt_busy", gnt_o, 0);
      req_i = 1'b0;
      if (idx < 0) begin
         check("miss_no_slv_req", slv_req_o, 0);
         check("miss_rvalid_early", rvalid_o, 0);
         @(negedge clk_i);
         check("miss_rvalid", rvalid_o, 1);
         check("miss_err", err_o, 1);
         check("miss_rdata", rdata_o, 0);
      end else begin
         check("slv_req", slv_req_o, 64'(1) << idx);
         check("slv_addr", slv_addr_o, addr);
         check("slv_we", slv_we_o, we);
         check("slv_wdata", slv_wdata_o, wd);
         check("slv_be", slv_be_o, be);
         for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk_i);
            check("slv_req_held", slv_req_o, 64'(1) << idx);
            check("slv_addr_held", slv_addr_o, addr);
         end
         slv_gnt_i[idx] = 1'b1;
         @(negedge clk_i);
         slv_gnt_i = '0;
         check("slv_req_dropped", slv_req_o, 0);
         if (expect_to) begin
            k = 0;
            while (!rvalid_o && k < T + 20) begin
               @(negedge clk_i);
               k++;
            end
            check("timeout_latency", 64'(k), 64'(T + 1));
            check("timeout_err", err_o, 1);
            check("timeout_rdata", rdata_o, 0);
         end else begin
            other = (idx + 1) % N;
            for (int i = 0; i < rsp_dly; i++) begin
               slv_rvalid_i[other] = 1'b1;
               slv_err_i[other] = 1'b1;
               slv_rdata_i[other*64 +: 64] = ~data;
               @(negedge clk_i);
               clear_slaves();
               check("stray_ignored", rvalid_o, 0);
            end
            slv_rvalid_i[idx] = 1'b1;
            slv_err_i[idx] = serr;
            slv_rdata_i[idx*64 +: 64] = data;
            slv_rvalid_i[other] = 1'b1;
            slv_err_i[other] = ~serr;
            slv_rdata_i[other*64 +: 64] = ~data;
            @(negedge clk_i);
            clear_slaves();
            check("rsp_rvalid", rvalid_o, 1);
            check("rsp_rdata", rdata_o, data);
            check("rsp_err", err_o, serr);
         end
      end
      @(negedge clk_i);
      check("rvalid_one_cycle", rvalid_o, 0);
   endtask

   initial begin
      logic [64:0] a65;
      int          r;
      clear_slaves();
      rst_i = 1'b1; req_i = 1'b1; addr_i = 64'h1000_0000; we_i = 1'b1;
      wdata_i = '1; be_i = '1;
      #12;
      check("rst_gnt", gnt_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_slv_req", slv_req_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_slv_addr", slv_addr_o, 0);
      check("rst_slv_wdata", slv_wdata_o, 0);
`ifdef SOC_ROUTER_ERRLOG_EN
      check("rst_err_valid", err_valid_o, 0);
`endif
      @(negedge clk_i);
      req_i = 1'b0; rst_i = 1'b0;

      // UART read, grant after 2 cycles, data 0xAB.
      do_txn(64'h1000_0008, 1'b0, 2, 1, 64'hAB, 1'b0, 1'b0);
      // Just past Debug: decode miss.
      do_txn(64'h0000_1000, 1'b1, 0, 0, 64'h0, 1'b0, 1'b0);
      // Top of DRAM: must hit without wrapping.
      do_txn(64'hFFFF_FFF8, 1'b0, 1, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
      // Slave error propagated.
      do_txn(64'h2100_0010, 1'b1, 0, 2, 64'hDEAD_BEEF, 1'b1, 1'b0);
      // CLINT grants but never answers.
      do_txn(64'h0200_0000, 1'b0, 0, 0, 64'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      slv_rvalid_i[7] = 1'b1; slv_rdata_i[7*64 +: 64] = 64'h5555;
      @(negedge clk_i);
      clear_slaves();
      check("late_rvalid_ignored", rvalid_o, 0);
      @(negedge clk_i);
      check("late_rvalid_ignored2", rvalid_o, 0);

      // Randomized traffic around region interiors and edges.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, N - 1));
         case ($urandom_range(0, 4))
            0:       a65 = BASE[r] + ({1'b0, $urandom, $urandom} % LEN[r]);
            1:       a65 = BASE[r];
            2:       a65 = BASE[r] + LEN[r] - 65'd1;
            3:       a65 = BASE[r] + LEN[r];
            default: a65 = {1'b0, $urandom, $urandom};
         endcase
         do_txn(a65[63:0], 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom), 1'b0);
      end

      // Reset while waiting for a grant.
      @(negedge clk_i);
      req_i = 1'b1; addr_i = 64'h1000_0008;
      @(negedge clk_i);
      req_i = 1'b0;
      check("pre_rst_slv_req", slv_req_o, 64'h020);
      rst_i = 1'b1;
      #1 check("rst_drops_slv_req", slv_req_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         slv_gnt_i[5] = 1'b1; slv_rvalid_i[5] = 1'b1; slv_rdata_i[5*64 +: 64] = 64'hAB;
         @(negedge clk_i);
         check("no_rsp_after_rst", rvalid_o, 0);
      end
      clear_slaves();
      @(negedge clk_i);
      check("no_rsp_after_rst_end", rvalid_o, 0);

`ifdef SOC_ROUTER_ERRLOG_EN
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("errlog_clear", err_valid_o, 0);
      do_txn(64'h0000_2000, 1'b0, 0, 0, 64'h0, 1'b0, 1'b0);
      do_txn(64'h0000_3000, 1'b0, 0, 0, 64'h0, 1'b0, 1'b0);
      check("errlog_valid", err_valid_o, 1);
      check("errlog_addr", err_addr_o, 64'h2000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
